// File: rtl/prbs_pkg.sv
// Shared definitions for the 8-bit XNOR PRBS (x^8+x^6+x^5+x^4+1) checker family.
package prbs_pkg;

   // Tap positions on the history register, h[0] = newest bit.
   localparam logic [7:0] PRBS_TAPS   = 8'b1011_1000;
   // All-ones is the XNOR lockup state; it also looks exactly like a stuck-high line.
   localparam logic [7:0] PRBS_LOCKUP = 8'hFF;

   typedef enum logic [1:0] {
      SEED   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } prbs_state_t;

   function automatic logic prbs_next(input logic [7:0] h);
      return ~^(h & PRBS_TAPS);
   endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Stream, control and status bundle between a PRBS source and the checker.
interface prbs_checker_if #(
   parameter int CNT_W = 16
);
   logic             i_valid;
   logic             i_bit;
   logic             i_clear;
   logic             o_locked;
   logic             o_err;
   logic [CNT_W-1:0] o_err_cnt;

   modport master (output i_valid, i_bit, i_clear, input o_locked, o_err, o_err_cnt);
   modport slave  (input i_valid, i_bit, i_clear, output o_locked, o_err, o_err_cnt);
endinterface

// File: rtl/prbs_predict.sv
// Combinational next-bit predictor for the 8-bit XNOR PRBS.
module prbs_predict
   import prbs_pkg::*;
(
   input  logic [7:0] i_hist,
   output logic       o_exp
);

   assign o_exp = prbs_next(i_hist);

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS-8 checker: seed, verify a run of predictions, then count errors.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int LOCK_CNT  = 16,
   parameter int ERR_LIMIT = 4,
   parameter int WINDOW    = 64,
   parameter int CNT_W     = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   prbs_checker_if.slave bus
);

   localparam int WIN_W = $clog2(WINDOW + 1);

   prbs_state_t      r_state;
   logic [7:0]       r_hist;
   logic [2:0]       r_seed_cnt;
   logic [7:0]       r_match_cnt;
   logic [WIN_W-1:0] r_win_cnt;
   logic [WIN_W-1:0] r_win_err;
   logic             r_locked;
   logic             r_err;
   logic [CNT_W-1:0] r_err_cnt;

   logic             w_exp;
   logic             w_mism;
   logic             w_err_evt;
   logic             w_match_done;
   logic             w_win_done;
   logic             w_err_limit;
   logic [7:0]       w_hist_rx;
   logic [8:0]       w_match_nxt;

   prbs_predict u_predict (
      .i_hist (r_hist),
      .o_exp  (w_exp)
   );

   assign w_mism       = bus.i_bit ^ w_exp;
   assign w_hist_rx    = {r_hist[6:0], bus.i_bit};
   assign w_match_nxt  = {1'b0, r_match_cnt} + 9'd1;
   assign w_match_done = (w_match_nxt >= 9'(LOCK_CNT));
   assign w_err_evt    = bus.i_valid && (r_state == LOCKED) && w_mism;
   assign w_win_done   = (r_win_cnt == WIN_W'(WINDOW - 1));
   assign w_err_limit  = ((r_win_err + WIN_W'(1)) == WIN_W'(ERR_LIMIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= SEED;
         r_hist      <= '0;
         r_seed_cnt  <= '0;
         r_match_cnt <= '0;
         r_win_cnt   <= '0;
         r_win_err   <= '0;
         r_locked    <= 1'b0;
         r_err       <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         r_err <= w_err_evt;
         // Clear beats a coincident error.
         if (bus.i_clear)
            r_err_cnt <= '0;
         else if (w_err_evt && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + CNT_W'(1);

         if (bus.i_valid) begin
            case (r_state)
               SEED: begin
                  r_hist     <= w_hist_rx;
                  r_seed_cnt <= r_seed_cnt + 3'd1;
                  if (r_seed_cnt == 3'd7) begin
                     r_state     <= VERIFY;
                     r_match_cnt <= '0;
                  end
               end
               VERIFY: begin
                  r_hist <= w_hist_rx;
                  if (w_mism) begin
                     r_state    <= SEED;
                     r_seed_cnt <= '0;
                  end else if (w_match_done) begin
                     if (w_hist_rx == PRBS_LOCKUP) begin
                        r_match_cnt <= 8'(LOCK_CNT);
                     end else begin
                        r_state   <= LOCKED;
                        r_locked  <= 1'b1;
                        r_win_cnt <= '0;
                        r_win_err <= '0;
                     end
                  end else begin
                     r_match_cnt <= w_match_nxt[7:0];
                  end
               end
               LOCKED: begin
                  // Feed back the prediction so one line error is seen only once.
                  r_hist <= {r_hist[6:0], w_exp};
                  if (w_mism && w_err_limit) begin
                     r_state    <= SEED;
                     r_locked   <= 1'b0;
                     r_seed_cnt <= '0;
                  end else if (w_win_done) begin
                     r_win_cnt <= '0;
                     r_win_err <= '0;
                  end else begin
                     r_win_cnt <= r_win_cnt + WIN_W'(1);
                     r_win_err <= r_win_err + WIN_W'(w_mism);
                  end
               end
               default: r_state <= SEED;
            endcase
         end
      end
   end

   assign bus.o_locked  = r_locked;
   assign bus.o_err     = r_err;
   assign bus.o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker with a behavioural model feeding a scoreboard queue.
module tb_prbs_checker;

   localparam int LOCK_CNT  = 16;
   localparam int ERR_LIMIT = 4;
   localparam int WINDOW    = 64;

   typedef struct {
      logic        locked;
      logic        err;
      logic [15:0] cnt;
      logic [1:0]  cnt2;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t q[$];
   int   n_vec;
   int   n_err;

   // model state
   int         m_st;
   int         m_seed;
   int         m_match;
   int         m_win;
   int         m_werr;
   int         m_cnt;
   int         m_cnt2;
   logic [7:0] m_h;
   logic       m_err;
   logic [7:0] g;

   prbs_checker_if #(.CNT_W(16)) ifc ();
   prbs_checker_if #(.CNT_W(2))  ifc2 ();

   assign ifc2.i_valid = ifc.i_valid;
   assign ifc2.i_bit   = ifc.i_bit;
   assign ifc2.i_clear = ifc.i_clear;

   prbs_checker #(.LOCK_CNT(LOCK_CNT), .ERR_LIMIT(ERR_LIMIT), .WINDOW(WINDOW), .CNT_W(16)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   prbs_checker #(.LOCK_CNT(LOCK_CNT), .ERR_LIMIT(ERR_LIMIT), .WINDOW(WINDOW), .CNT_W(2)) u_dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc2.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_seed = 0; m_match = 0; m_win = 0; m_werr = 0;
      m_cnt = 0; m_cnt2 = 0; m_h = 8'h00; m_err = 1'b0;
   endtask

   task automatic model_step(input logic v, input logic b, input logic clr);
      logic e;
      logic mism;
      m_err = 1'b0;
      mism  = 1'b0;
      if (v) begin
         e = ~(m_h[7] ^ m_h[5] ^ m_h[4] ^ m_h[3]);
         case (m_st)
            0: begin
               m_h = {m_h[6:0], b};
               m_seed++;
               if (m_seed == 8) begin m_st = 1; m_seed = 0; m_match = 0; end
            end
            1: begin
               m_h = {m_h[6:0], b};
               if (b !== e) begin
                  m_st = 0; m_seed = 0;
               end else begin
                  m_match++;
                  if (m_match >= LOCK_CNT) begin
                     if (m_h == 8'hFF) m_match = LOCK_CNT;
                     else begin m_st = 2; m_win = 0; m_werr = 0; end
                  end
               end
            end
            default: begin
               m_h  = {m_h[6:0], e};
               mism = (b !== e);
               m_err = mism;
               m_win++;
               if (mism) m_werr++;
               if (mism && m_werr == ERR_LIMIT) begin
                  m_st = 0; m_seed = 0;
               end else if (m_win == WINDOW) begin
                  m_win = 0; m_werr = 0;
               end
            end
         endcase
      end
      if (clr) begin
         m_cnt = 0; m_cnt2 = 0;
      end else if (mism) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt2 < 3) m_cnt2++;
      end
   endtask

   // Drive one cycle, queue the model's prediction, then compare after the edge.
   task automatic step(input logic v, input logic b, input logic clr);
      exp_t ex;
      exp_t got;
      ifc.i_valid = v;
      ifc.i_bit   = b;
      ifc.i_clear = clr;
      model_step(v, b, clr);
      ex.locked = (m_st == 2);
      ex.err    = m_err;
      ex.cnt    = 16'(m_cnt);
      ex.cnt2   = 2'(m_cnt2);
      q.push_back(ex);
      @(posedge clk);
      #1;
      got = q.pop_front();
      chk("sb_locked", {31'd0, ifc.o_locked}, {31'd0, got.locked});
      chk("sb_err",    {31'd0, ifc.o_err},    {31'd0, got.err});
      chk("sb_cnt",    {16'd0, ifc.o_err_cnt}, {16'd0, got.cnt});
      chk("sb_cnt2",   {30'd0, ifc2.o_err_cnt}, {30'd0, got.cnt2});
   endtask

   task automatic send(input logic flip, input logic clr);
      logic b;
      b = ~(g[7] ^ g[5] ^ g[4] ^ g[3]);
      g = {g[6:0], b};
      step(1'b1, b ^ flip, clr);
   endtask

   task automatic align(input int pos);
      for (int i = 0; i < 2 * WINDOW && m_win != pos; i++) send(1'b0, 1'b0);
   endtask

   task automatic relock(input string tag);
      for (int i = 1; i <= 24; i++) begin
         send(1'b0, 1'b0);
         if (i == 23) chk({tag, "_pre"}, {31'd0, ifc.o_locked}, 32'd0);
      end
      chk(tag, {31'd0, ifc.o_locked}, 32'd1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ifc.i_valid = 1'b0;
      ifc.i_bit   = 1'b0;
      ifc.i_clear = 1'b0;
      model_reset();
      g = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_locked", {31'd0, ifc.o_locked}, 32'd0);
      chk("rst_err",    {31'd0, ifc.o_err}, 32'd0);
      chk("rst_cnt",    {16'd0, ifc.o_err_cnt}, 32'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      int nv;
      n_vec = 0;
      n_err = 0;

      // Clean continuous stream: lock on the 24th bit, no errors over 1000 bits.
      do_reset();
      relock("lock24");
      for (int i = 24; i < 1000; i++) send(1'b0, 1'b0);
      chk("clean_cnt", {16'd0, ifc.o_err_cnt}, 32'd0);

      // Single inverted bit while locked, then clear.
      send(1'b1, 1'b0);
      chk("single_err",    {31'd0, ifc.o_err}, 32'd1);
      chk("single_cnt",    {16'd0, ifc.o_err_cnt}, 32'd1);
      chk("single_locked", {31'd0, ifc.o_locked}, 32'd1);
      send(1'b0, 1'b0);
      chk("single_pulse_end", {31'd0, ifc.o_err}, 32'd0);
      step(1'b0, 1'b0, 1'b1);
      chk("clear_cnt", {16'd0, ifc.o_err_cnt}, 32'd0);

      // Clear and error in the same cycle: clear wins, pulse still fires.
      send(1'b1, 1'b1);
      chk("clr_vs_err_cnt", {16'd0, ifc.o_err_cnt}, 32'd0);
      chk("clr_vs_err_pulse", {31'd0, ifc.o_err}, 32'd1);

      // Four errors inside one window drop lock on the fourth.
      align(0);
      for (int k = 0; k < 4; k++) begin
         send(1'b1, 1'b0);
         if (k == 2) chk("burst_locked3", {31'd0, ifc.o_locked}, 32'd1);
         if (k < 3) begin send(1'b0, 1'b0); send(1'b0, 1'b0); end
      end
      chk("burst_unlock", {31'd0, ifc.o_locked}, 32'd0);
      chk("burst_cnt", {16'd0, ifc.o_err_cnt}, 32'd4);
      relock("burst_relock");

      // Window boundary: the completing bit is the fourth error of its window.
      step(1'b0, 1'b0, 1'b1);
      align(0);
      repeat (WINDOW - 4) send(1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         send(1'b1, 1'b0);
         if (k == 2) chk("edge_locked3", {31'd0, ifc.o_locked}, 32'd1);
      end
      chk("edge_unlock", {31'd0, ifc.o_locked}, 32'd0);
      relock("edge_relock");

      // Isolated errors, one per window: narrow counter saturates at 3.
      step(1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         align(0);
         send(1'b1, 1'b0);
      end
      chk("sat_cnt2",   {30'd0, ifc2.o_err_cnt}, 32'd3);
      chk("sat_cnt16",  {16'd0, ifc.o_err_cnt}, 32'd6);
      chk("sat_locked", {31'd0, ifc.o_locked}, 32'd1);

      // Asynchronous reset mid-lock.
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_locked", {31'd0, ifc.o_locked}, 32'd0);
      chk("async_cnt",    {16'd0, ifc.o_err_cnt}, 32'd0);
      chk("async_cnt2",   {30'd0, ifc2.o_err_cnt}, 32'd0);
      chk("async_err",    {31'd0, ifc.o_err}, 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      relock("reseed_relock");

      // Randomly gapped valid: lock after the 24th valid bit.
      do_reset();
      nv = 0;
      for (int i = 0; i < 600 && nv < 24; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            nv++;
            send(1'b0, 1'b0);
            if (nv == 23) chk("gap_pre", {31'd0, ifc.o_locked}, 32'd0);
         end else begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
         end
      end
      chk("gap_lock", {31'd0, ifc.o_locked}, 32'd1);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 1) == 1) send(1'b0, 1'b0);
         else step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
      chk("gap_cnt", {16'd0, ifc.o_err_cnt}, 32'd0);

      // Stuck-high and stuck-low lines never lock.
      do_reset();
      repeat (300) step(1'b1, 1'b1, 1'b0);
      chk("stuck1_locked", {31'd0, ifc.o_locked}, 32'd0);
      do_reset();
      repeat (300) step(1'b1, 1'b0, 1'b0);
      chk("stuck0_locked", {31'd0, ifc.o_locked}, 32'd0);
      chk("stuck0_cnt", {16'd0, ifc.o_err_cnt}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial checker for the 8-bit XNOR PRBS stream produced by the team's LFSR generator (taps 8,6,5,4, period 255). It self-synchronises to the incoming bit stream, declares lock after a run of correct predictions, and then counts bit errors against the locally predicted sequence. It sits at the receive end of a link or loopback test, opposite the generator.

## Interface
- `LOCK_CNT`, 16: consecutive correctly predicted bits required (after seeding) to declare lock; range 1..255.
- `ERR_LIMIT`, 4: errors within one window that drop lock; range 1..`WINDOW`.
- `WINDOW`, 64: window length in valid bits while locked; range 2..1024.
- `CNT_W`, 16: width of error counter.
- `clk`  in  1  clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_valid`  in  1  `i_bit` carries a stream bit this cycle.
- `i_bit`  in  1  received serial PRBS bit.
- `i_clear`  in  1  synchronous clear of `o_err_cnt`.
- `o_locked`  out  1  checker is in `LOCKED`.
- `o_err`  out  1  one-cycle pulse per mismatched bit while locked.
- `o_err_cnt`  out  `CNT_W`  saturating count of errors seen while locked.

## Operation
- Sequence definition: with history h[7:0], h[0] = newest bit, h[7] = bit 8 back, expected bit e = ~(h[7]^h[5]^h[4]^h[3]). On each accepted bit the history shifts left, and the new bit enters h[0].
- Only cycles with `i_valid`=1 advance state, history, or counters. `i_valid`=0 cycles are ignored entirely.
- States:
  - `SEED`: shift in the received bit; count 8 bits; then go to `VERIFY` with the match count at 0.
  - `VERIFY`: compare `i_bit` with e and shift in the received bit.
    - On a match, increment the match count.
    - On a mismatch, return to `SEED` with the seed count at 0.
    - When the match count reaches `LOCK_CNT`, go to `LOCKED`, unless the history equals 8'hFF. The all-ones state is the XNOR lockup state and is treated as a stuck-high line, so stay in `VERIFY` and hold the match count at `LOCK_CNT`.
  - `LOCKED`: compare `i_bit` with e.
    - Shift e, not `i_bit`, into the history. A single line error is therefore counted once, not multiplied by the taps.
    - On a mismatch, pulse `o_err` and increment `o_err_cnt`, saturating at 2^`CNT_W`−1.
    - The window counter counts valid bits. The window error counter counts mismatches and clears when the window completes (`WINDOW` bits).
    - When the window error count reaches `ERR_LIMIT`, go to `SEED`. The error that triggers this still pulses `o_err` and is counted.
- Error counting happens only in `LOCKED`. Mismatches in `VERIFY` never touch `o_err`/`o_err_cnt`.
- `i_clear`: `o_err_cnt` becomes 0 on the next edge. If an error occurs in the same cycle, clear wins and the result is 0. The state machine and the window counters are unaffected.

## Timing
- All outputs are registered. `o_err` goes high in the cycle after the edge that sampled the mismatching bit, and `o_err_cnt` updates on that same edge.
- `o_locked` rises on the edge that accepts the `LOCK_CNT`-th verified bit. From reset with a clean, continuous stream, that is the 8+`LOCK_CNT` = 24th valid bit.
- `o_locked` falls on the edge that accepts the error reaching `ERR_LIMIT`.
- Reset values: `o_locked`=0, `o_err`=0, `o_err_cnt`=0, state `SEED`, history 0, all internal counters 0.
- Reset asserted mid-lock returns to `SEED` immediately (asynchronously). The checker reseeds from the first valid bit after release.
- Window boundary: the bit that completes a window is counted in the old window, and the window error counter clears after it. If that bit is also the `ERR_LIMIT`-th error, lock drops.

## Structure
- Shared package `prbs_pkg`: tap constant for the 8-bit XNOR polynomial (taps 7,5,4,3 on h), lockup value 8'hFF, state enum {`SEED`, `VERIFY`, `LOCKED`}.
- One natural sub-module, `prbs_predict`: combinational, takes h and returns e. It is shared with any future parallel checker.
- Counter widths:
  - seed counter: 3 bits;
  - match counter: 8 bits;
  - window counters: clog2(`WINDOW`+1) bits.

## Test plan
- Clean stream from a generator seeded at reset, `i_valid`=1 continuously -> `o_locked`=1 after the 24th bit; `o_err_cnt` stays 0 over 1000 bits.
- Same stream with `i_valid` toggling 1/0 randomly -> lock after the 24th *valid* bit; behaviour identical to the continuous case.
- While locked, invert one bit -> exactly one `o_err` pulse, `o_err_cnt`=1, `o_locked` stays 1; `i_clear` then returns the count to 0.
- While locked, invert 4 bits within 64 -> `o_err_cnt`=4, `o_locked` falls on the 4th error, then relocks 24 valid bits later.
- Input stuck at 1 -> `o_locked` never rises. Input stuck at 0 -> repeated mismatches in `VERIFY`, never locks.
- `CNT_W`=2 with 6 isolated errors (at most 3 per window) -> `o_err_cnt` saturates at 3. Reset asserted mid-lock -> all outputs 0 immediately.
